// File: rtl/mp64_xbuf_if.sv
// Host register-access bus for mp64_xbuf: strobe, offset, data and completion.
interface mp64_xbuf_if;
    logic        req;
    logic [5:0]  addr;
    logic [63:0] wdata;
    logic        wen;
    logic [63:0] rdata;
    logic        ack;

    modport master (output req, output addr, output wdata, output wen,
                    input  rdata, input ack);
    modport slave  (input  req, input  addr, input  wdata, input  wen,
                    output rdata, output ack);
endinterface

// File: rtl/mp64_xbuf.sv
// Multi-buffer byte store shared between a 64-bit host register port and a
// byte-wide core port, with a command handshake that hands storage to the core.
module mp64_xbuf #(
    parameter int unsigned         NBUF  = 5,
    parameter int unsigned         DEPTH = 2048,
    parameter logic [NBUF*16-1:0]  SIZES = {16'd32, 16'd768, 16'd1632, 16'd800, 16'd64}
) (
    input  logic        clk,
    input  logic        rst,
    mp64_xbuf_if.slave  host,
    output logic        o_cmd_start,
    output logic [2:0]  o_cmd_code,
    input  logic        i_core_done,
    input  logic        i_core_err,
    input  logic [2:0]  i_core_bsel,
    input  logic [15:0] i_core_addr,
    input  logic        i_core_we,
    input  logic [7:0]  i_core_wdata,
    output logic [7:0]  o_core_rdata
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FW = 5;

    localparam logic [5:0] A_CMD     = 6'h00;
    localparam logic [5:0] A_BUF_SEL = 6'h08;
    localparam logic [5:0] A_DATA8   = 6'h10;
    localparam logic [5:0] A_IDX_SET = 6'h18;
    localparam logic [5:0] A_IDX     = 6'h20;
    localparam logic [5:0] A_DATA64  = 6'h28;
    localparam logic [5:0] A_ERR_CLR = 6'h30;

    localparam int unsigned F_OVF     = 0;
    localparam int unsigned F_BADSEL  = 1;
    localparam int unsigned F_CMDBUSY = 2;
    localparam int unsigned F_LOCKED  = 3;
    localparam int unsigned F_COLLIDE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t          r_state;
    logic [FW-1:0]   r_flags;
    logic [2:0]      r_bsel;
    logic [15:0]     r_idx;
    logic [63:0]     r_rdata;
    logic            r_ack;
    logic            r_cmd_start;
    logic [2:0]      r_cmd_code;
    logic [7:0]      r_core_rdata;

    // DATA64 byte engine: byte 0 is handled on the request edge, bytes 1..7 follow
    logic            r_d64_active;
    logic [2:0]      r_d64_cnt;
    logic            r_d64_wen;
    logic [63:0]     r_d64_wdata;
    logic [63:0]     r_d64_acc;
    logic            r_d64_lock;

    logic [7:0]      r_mem [NBUF][DEPTH];

    logic            w_busy;
    logic [15:0]     w_size;
    logic            w_accept;
    logic            w_collide;
    logic            w_is_d8;
    logic            w_is_d64;
    logic            w_lock;
    logic            w_byte_op;
    logic            w_byte_we;
    logic [7:0]      w_byte_wd;
    logic            w_in_bounds;
    logic [7:0]      w_rbyte;
    logic            w_host_we;
    logic            w_core_ok;
    logic            w_sel_ok;
    logic            w_wr_cmd;
    logic            w_wr_sel;
    logic            w_wr_idx;
    logic            w_idx_clamp;
    logic [63:0]     w_rd;
    logic [FW-1:0]   w_flag_set;
    logic [FW-1:0]   w_flag_clr;

    assign host.rdata   = r_rdata;
    assign host.ack     = r_ack;
    assign o_cmd_start  = r_cmd_start;
    assign o_cmd_code   = r_cmd_code;
    assign o_core_rdata = r_core_rdata;

    // Decode host request, byte-access datapath, read mux and flag events
    always_comb begin
        w_busy      = (r_state == ST_BUSY);
        w_size      = 16'd0;
        for (int i = 0; i < NBUF; i++) begin
            if (32'(r_bsel) == i) w_size = SIZES[16*i +: 16];
        end
        w_accept    = host.req && !r_d64_active;
        w_collide   = host.req && r_d64_active;
        w_is_d8     = w_accept && (host.addr == A_DATA8);
        w_is_d64    = w_accept && (host.addr == A_DATA64);
        w_lock      = r_d64_active ? r_d64_lock : w_busy;
        w_byte_op   = (w_is_d8 || w_is_d64 || r_d64_active) && !w_lock;
        w_byte_we   = r_d64_active ? r_d64_wen : host.wen;
        w_byte_wd   = r_d64_active ? 8'(r_d64_wdata >> {r_d64_cnt, 3'b000}) : host.wdata[7:0];
        w_in_bounds = (r_idx < w_size);
        w_rbyte     = 8'h00;
        if (w_byte_op && w_in_bounds && !w_byte_we) w_rbyte = r_mem[r_bsel][r_idx[AW-1:0]];
        w_host_we   = w_byte_op && w_byte_we && w_in_bounds;
        w_core_ok   = w_busy && (32'(i_core_bsel) < NBUF) && (32'(i_core_addr) < DEPTH);

        w_wr_cmd    = w_accept && host.wen && (host.addr == A_CMD);
        w_wr_sel    = w_accept && host.wen && (host.addr == A_BUF_SEL);
        w_wr_idx    = w_accept && host.wen && (host.addr == A_IDX_SET);
        w_sel_ok    = (host.wdata < 64'(NBUF));
        w_idx_clamp = (host.wdata[15:0] > w_size);

        w_rd = 64'd0;
        case (host.addr)
            A_CMD:     w_rd = {48'd0, 3'd0, r_flags, 6'd0, r_state};
            A_BUF_SEL: w_rd = 64'(r_bsel);
            A_DATA8:   w_rd = 64'(w_rbyte);
            A_IDX_SET: w_rd = 64'(w_size);
            A_IDX:     w_rd = 64'(r_idx);
            default:   w_rd = 64'd0;
        endcase

        w_flag_set            = '0;
        w_flag_set[F_OVF]     = (w_byte_op && !w_in_bounds) || (w_wr_idx && w_idx_clamp);
        w_flag_set[F_BADSEL]  = w_wr_sel && !w_sel_ok;
        w_flag_set[F_CMDBUSY] = w_wr_cmd && w_busy;
        w_flag_set[F_LOCKED]  = (w_is_d8 || w_is_d64) && w_busy;
        w_flag_set[F_COLLIDE] = w_collide;
        w_flag_clr = (w_accept && host.wen && (host.addr == A_ERR_CLR)) ? host.wdata[FW-1:0] : '0;
    end

    // Control state, command FSM, index, flags, DATA64 engine and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_flags      <= '0;
            r_bsel       <= 3'd0;
            r_idx        <= 16'd0;
            r_rdata      <= 64'd0;
            r_ack        <= 1'b0;
            r_cmd_start  <= 1'b0;
            r_cmd_code   <= 3'd0;
            r_core_rdata <= 8'd0;
            r_d64_active <= 1'b0;
            r_d64_cnt    <= 3'd0;
            r_d64_wen    <= 1'b0;
            r_d64_wdata  <= 64'd0;
            r_d64_acc    <= 64'd0;
            r_d64_lock   <= 1'b0;
        end else begin
            r_ack        <= 1'b0;
            r_cmd_start  <= 1'b0;
            r_flags      <= (r_flags & ~w_flag_clr) | w_flag_set;
            r_core_rdata <= w_core_ok ? r_mem[i_core_bsel][i_core_addr[AW-1:0]] : 8'd0;

            if (w_byte_op && w_in_bounds) r_idx <= r_idx + 16'd1;

            if (w_busy && i_core_done) r_state <= i_core_err ? ST_ERR : ST_DONE;

            if (w_wr_cmd && !w_busy && (host.wdata[2:0] != 3'd0)) begin
                r_cmd_code  <= host.wdata[2:0];
                r_cmd_start <= 1'b1;
                r_state     <= ST_BUSY;
            end
            if (w_wr_sel && w_sel_ok) begin
                r_bsel <= host.wdata[2:0];
                r_idx  <= 16'd0;
            end
            if (w_wr_idx) r_idx <= w_idx_clamp ? w_size : host.wdata[15:0];

            if (w_accept && !w_is_d64) begin
                r_ack   <= 1'b1;
                r_rdata <= host.wen ? 64'd0 : w_rd;
            end

            if (w_is_d64) begin
                r_d64_active <= 1'b1;
                r_d64_cnt    <= 3'd1;
                r_d64_wen    <= host.wen;
                r_d64_wdata  <= host.wdata;
                r_d64_lock   <= w_busy;
                r_d64_acc    <= 64'(w_rbyte);
            end else if (r_d64_active) begin
                r_d64_acc <= r_d64_acc | (64'(w_rbyte) << {r_d64_cnt, 3'b000});
                r_d64_cnt <= r_d64_cnt + 3'd1;
                if (r_d64_cnt == 3'd7) begin
                    r_d64_active <= 1'b0;
                    r_ack        <= 1'b1;
                    r_rdata      <= r_d64_wen ? 64'd0 : (r_d64_acc | (64'(w_rbyte) << 56));
                end
            end
        end
    end

    // Byte storage: host owns it outside busy, core owns it while busy; never reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_host_we) begin
                r_mem[r_bsel][r_idx[AW-1:0]] <= w_byte_wd;
            end else if (w_core_ok && i_core_we) begin
                r_mem[i_core_bsel][i_core_addr[AW-1:0]] <= i_core_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mp64_xbuf.sv
// Directed scoreboard bench for mp64_xbuf: stimulus queues expected host
// responses, an independent monitor pops and checks them on every ack.
module tb_mp64_xbuf;

    typedef struct {
        logic [63:0] rd;
        bit          chk;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_done, core_err, core_we;
    logic [2:0]  core_bsel;
    logic [15:0] core_addr;
    logic [7:0]  core_wdata;
    logic        cmd_start;
    logic [2:0]  cmd_code;
    logic [7:0]  core_rdata;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t q[$];
    exp_t m_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mp64_xbuf_if u_host ();

    mp64_xbuf #(
        .NBUF (5),
        .DEPTH(2048),
        .SIZES({16'd32, 16'd768, 16'd1632, 16'd800, 16'd64})
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (u_host),
        .o_cmd_start (cmd_start),
        .o_cmd_code  (cmd_code),
        .i_core_done (core_done),
        .i_core_err  (core_err),
        .i_core_bsel (core_bsel),
        .i_core_addr (core_addr),
        .i_core_we   (core_we),
        .i_core_wdata(core_wdata),
        .o_core_rdata(core_rdata)
    );

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endfunction

    // Monitor: every ack must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && u_host.ack) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
            end else begin
                m_e = q.pop_front();
                check({m_e.name, "_ack_cycle"}, 64'(cyc), 64'(m_e.cyc));
                if (m_e.chk) check(m_e.name, u_host.rdata, m_e.rd);
            end
        end
    end

    // One-cycle host strobe issued on a falling edge; optionally queues the expected ack
    task automatic fire(input logic [5:0] a, input logic w, input logic [63:0] d,
                        input logic [63:0] er, input bit ck, input string nm,
                        input int lat, input bit exp_ack);
        exp_t e;
        if (exp_ack) begin
            e.rd = er; e.chk = ck; e.cyc = cyc + lat; e.name = nm;
            q.push_back(e);
        end
        u_host.req = 1'b1; u_host.addr = a; u_host.wen = w; u_host.wdata = d;
        @(negedge clk);
        u_host.req = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [63:0] d);
        fire(a, 1'b1, d, 64'd0, 1'b0, "wr", 1, 1'b1);
    endtask

    task automatic rd(input logic [5:0] a, input logic [63:0] er, input string nm);
        fire(a, 1'b0, 64'd0, er, 1'b1, nm, 1, 1'b1);
    endtask

    task automatic d64rd(input logic [63:0] er, input string nm);
        fire(6'h28, 1'b0, 64'd0, er, 1'b1, nm, 8, 1'b1);
        repeat (7) @(negedge clk);
    endtask

    task automatic d64wr(input logic [63:0] d);
        fire(6'h28, 1'b1, d, 64'd0, 1'b0, "d64wr", 8, 1'b1);
        repeat (7) @(negedge clk);
    endtask

    task automatic core_rd(input logic [2:0] b, input logic [15:0] a, input logic [7:0] er, input string nm);
        core_bsel = b; core_addr = a; core_we = 1'b0;
        @(negedge clk);
        check(nm, 64'(core_rdata), 64'(er));
    endtask

    task automatic core_wr(input logic [2:0] b, input logic [15:0] a, input logic [7:0] d);
        core_bsel = b; core_addr = a; core_wdata = d; core_we = 1'b1;
        @(negedge clk);
        core_we = 1'b0;
    endtask

    task automatic core_fin(input logic err);
        core_done = 1'b1; core_err = err;
        @(negedge clk);
        core_done = 1'b0; core_err = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sz[5];
        sz = '{64, 800, 1632, 768, 32};
        rst = 1'b1;
        u_host.req = 1'b0; u_host.addr = 6'd0; u_host.wen = 1'b0; u_host.wdata = 64'd0;
        core_done = 1'b0; core_err = 1'b0; core_we = 1'b0;
        core_bsel = 3'd0; core_addr = 16'd0; core_wdata = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {53'd0, u_host.ack, cmd_start, cmd_code, core_rdata}, 64'd0);
        check("rst_rdata", u_host.rdata, 64'd0);
        rst = 1'b0;

        rd(6'h00, 64'h0, "status_rst");
        rd(6'h08, 64'h0, "bsel_rst");
        rd(6'h20, 64'h0, "idx_rst");

        // Buffer sizes and bad selection
        for (int b = 0; b < 5; b++) begin
            wr(6'h08, 64'(b));
            rd(6'h18, 64'(sz[b]), "buf_size");
        end
        wr(6'h08, 64'd5);
        rd(6'h08, 64'd4, "bsel_kept");
        rd(6'h00, 64'h0200, "badsel_flag");
        wr(6'h30, 64'h1F);
        rd(6'h00, 64'h0, "flags_cleared");

        // DATA8 fill then DATA64 reads
        wr(6'h08, 64'd0);
        for (int i = 0; i < 16; i++) wr(6'h10, 64'(i ^ 8'hAA));
        rd(6'h20, 64'd16, "idx_after_fill");
        wr(6'h08, 64'd0);
        d64rd(64'hADACAFAEA9A8ABAA, "d64_rd_lo");
        rd(6'h20, 64'd8, "idx_after_d64");
        d64rd(64'hA5A4A7A6A1A0A3A2, "d64_rd_hi");
        rd(6'h20, 64'd16, "idx_after_d64_2");
        rd(6'h00, 64'h0, "no_flags");

        // Boundary on buffer 4 (size 32)
        wr(6'h08, 64'd4);
        wr(6'h18, 64'd28);
        d64wr(64'h1122334455667788);
        rd(6'h20, 64'd32, "idx_saturated");
        rd(6'h00, 64'h0100, "ovf_flag");
        rd(6'h10, 64'h0, "d8_past_end");
        rd(6'h20, 64'd32, "idx_still_sat");
        wr(6'h18, 64'd28);
        rd(6'h10, 64'h88, "b28");
        rd(6'h10, 64'h77, "b29");
        rd(6'h10, 64'h66, "b30");
        rd(6'h10, 64'h55, "b31");
        wr(6'h30, 64'h1F);
        wr(6'h18, 64'd40);
        rd(6'h20, 64'd32, "idx_clamped");
        rd(6'h00, 64'h0100, "clamp_ovf");
        wr(6'h30, 64'h1F);

        // Command handshake, lockout and core access
        wr(6'h08, 64'd0);
        wr(6'h00, 64'd1);
        check("cmd_start_pulse", {61'd0, cmd_start, 2'd0}, 64'h4);
        check("cmd_code_1", 64'(cmd_code), 64'd1);
        @(negedge clk);
        check("cmd_start_drop", 64'(cmd_start), 64'd0);
        rd(6'h00, 64'h0001, "status_busy");
        wr(6'h00, 64'd2);
        rd(6'h00, 64'h0401, "cmdbusy_flag");
        check("cmd_code_kept", 64'(cmd_code), 64'd1);
        wr(6'h10, 64'h55);
        rd(6'h00, 64'h0C01, "locked_flag");
        rd(6'h20, 64'd0, "idx_locked");
        rd(6'h10, 64'd0, "d8_locked_rd");
        d64rd(64'd0, "d64_locked_rd");
        core_rd(3'd0, 16'd0, 8'hAA, "core_rd0");
        core_rd(3'd0, 16'd3, 8'hA9, "core_rd3");
        core_wr(3'd1, 16'd5, 8'h3C);
        core_rd(3'd5, 16'd0, 8'h00, "core_bad_bsel");
        core_fin(1'b0);
        rd(6'h00, 64'h0C02, "status_done");
        core_rd(3'd0, 16'd0, 8'h00, "core_rd_idle");
        rd(6'h10, 64'hAA, "storage_kept");
        wr(6'h08, 64'd1);
        wr(6'h18, 64'd5);
        rd(6'h10, 64'h3C, "core_wr_landed");
        wr(6'h18, 64'd6);
        wr(6'h10, 64'h11);
        core_wr(3'd1, 16'd6, 8'h99);
        wr(6'h18, 64'd6);
        rd(6'h10, 64'h11, "core_wr_idle");

        // Error completion and flag clearing
        wr(6'h30, 64'h1F);
        rd(6'h00, 64'h0002, "clr_done");
        wr(6'h00, 64'd0);
        rd(6'h00, 64'h0002, "cmd0_ignored");
        wr(6'h00, 64'd3);
        check("cmd_code_3", 64'(cmd_code), 64'd3);
        core_fin(1'b1);
        rd(6'h00, 64'h0003, "status_error");
        core_fin(1'b0);
        rd(6'h00, 64'h0003, "done_ignored");
        wr(6'h08, 64'd9);
        rd(6'h00, 64'h0203, "badsel_err");
        wr(6'h30, 64'h1F);
        rd(6'h00, 64'h0003, "errclr_all");

        // Collision during DATA64
        wr(6'h08, 64'd0);
        fire(6'h28, 1'b0, 64'd0, 64'hADACAFAEA9A8ABAA, 1'b1, "d64_coll", 8, 1'b1);
        @(negedge clk);
        fire(6'h00, 1'b0, 64'd0, 64'd0, 1'b0, "dropped", 1, 1'b0);
        repeat (5) @(negedge clk);
        rd(6'h00, 64'h1003, "collide_flag");
        rd(6'h20, 64'd8, "idx_coll");

        // Reset aborting a DATA64 access
        wr(6'h18, 64'd0);
        fire(6'h28, 1'b0, 64'd0, 64'd0, 1'b0, "aborted", 8, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", {53'd0, u_host.ack, cmd_start, cmd_code, core_rdata}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        rd(6'h00, 64'h0, "status_after_rst");
        rd(6'h08, 64'h0, "bsel_after_rst");
        rd(6'h20, 64'h0, "idx_after_rst");
        rd(6'h10, 64'hAA, "data_retained");
        repeat (10) @(negedge clk);

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
